// File: rtl/game_state_ctrl.sv
// Game flow controller for a Frogger-style game. Tracks the current game
// phase (idle, play, dying, scored, game over), the player's lives, score
// and level, and produces the enables and pulses that drive the frog, the
// cars and the video blink.
module game_state_ctrl #(
  parameter int c_LIVES        = 3,
  parameter int c_DEATH_FRAMES = 60,
  parameter int c_SCORE_FRAMES = 30,
  parameter int c_LEVEL_STEP   = 5,
  parameter int c_MAX_LEVEL    = 7,
  parameter int c_MAX_SCORE    = 99,
  parameter int c_GOAL_ROW     = 0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_VSync,
  input  logic       i_Game_Start,
  input  logic       i_Collided,
  input  logic [5:0] i_Frogger_Y,
  output logic [2:0] o_State,
  output logic       o_Frog_Reset,
  output logic       o_Move_Enable,
  output logic       o_Cars_Enable,
  output logic       o_Flash,
  output logic [1:0] o_Lives,
  output logic [6:0] o_Score,
  output logic [2:0] o_Level
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    SCORED    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // The frame counter must hold the longer of the two timed phases, and at
  // least three bits so the 8-frame blink period can be read from it.
  localparam int MAX_FRAMES = (c_DEATH_FRAMES > c_SCORE_FRAMES) ? c_DEATH_FRAMES : c_SCORE_FRAMES;
  localparam int FRAME_W    = ($clog2(MAX_FRAMES + 1) < 3) ? 3 : $clog2(MAX_FRAMES + 1);
  localparam int STEP_W     = (c_LEVEL_STEP > 1) ? $clog2(c_LEVEL_STEP) : 1;

  localparam logic [FRAME_W-1:0] DEATH_LAST = FRAME_W'(c_DEATH_FRAMES - 1);
  localparam logic [FRAME_W-1:0] SCORE_LAST = FRAME_W'(c_SCORE_FRAMES - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(c_LEVEL_STEP - 1);
  localparam logic [1:0]         LIVES_INIT = 2'(c_LIVES);
  localparam logic [6:0]         MAX_SCORE  = 7'(c_MAX_SCORE);
  localparam logic [2:0]         MAX_LEVEL  = 3'(c_MAX_LEVEL);
  localparam logic [5:0]         GOAL_ROW   = 6'(c_GOAL_ROW);

  state_t               state;
  state_t               state_nxt;
  logic                 vsync_q;
  logic                 start_q;
  logic                 tick;
  logic                 start_edge;
  logic                 collide_hit;
  logic                 goal_hit;
  logic                 entering;
  logic                 coll_block;
  logic [FRAME_W-1:0]   frame_cnt;
  logic [STEP_W-1:0]    step_cnt;
  logic                 frog_reset;
  logic                 move_en;
  logic                 cars_en;
  logic                 flash;
  logic [1:0]           lives;
  logic [6:0]           score;
  logic [2:0]           level;

  assign tick       = i_VSync & ~vsync_q;
  assign start_edge = i_Game_Start & ~start_q;
  // A held collision only costs one life: coll_block stays set until the
  // collision input drops.
  assign collide_hit = i_Collided & ~coll_block;
  assign goal_hit    = (i_Frogger_Y == GOAL_ROW) & ~i_Collided;
  assign entering    = (state_nxt != state);

  // Delay the frame sync and start button by one cycle for edge detection.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      vsync_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      vsync_q <= i_VSync;
      start_q <= i_Game_Start;
    end
  end

  // Decide the next game phase from the current phase and this cycle's events.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, GAME_OVER: if (start_edge) state_nxt = PLAY;
      PLAY: begin
        if (collide_hit)   state_nxt = DYING;
        else if (goal_hit) state_nxt = SCORED;
      end
      DYING:  if (tick && frame_cnt == DEATH_LAST) state_nxt = (lives == 2'd0) ? GAME_OVER : PLAY;
      SCORED: if (tick && frame_cnt == SCORE_LAST) state_nxt = PLAY;
      default: state_nxt = IDLE;
    endcase
  end

  // Register the phase, all outputs and the game counters together.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      step_cnt   <= '0;
      coll_block <= 1'b0;
      frog_reset <= 1'b0;
      move_en    <= 1'b0;
      cars_en    <= 1'b0;
      flash      <= 1'b0;
      lives      <= LIVES_INIT;
      score      <= '0;
      level      <= '0;
    end else begin
      state      <= state_nxt;
      move_en    <= (state_nxt == PLAY);
      cars_en    <= (state_nxt == PLAY) || (state_nxt == DYING) || (state_nxt == SCORED);
      frog_reset <= entering && ((state_nxt == PLAY) || (state_nxt == SCORED));

      // A tick in the cycle that changes phase belongs to neither phase.
      if (entering)
        frame_cnt <= '0;
      else if (tick && (state == DYING || state == SCORED))
        frame_cnt <= frame_cnt + FRAME_W'(1);

      // Blink starts lit on entering DYING and flips on every 8th tick.
      if (state_nxt != DYING)
        flash <= 1'b0;
      else if (entering)
        flash <= 1'b1;
      else if (tick && frame_cnt[2:0] == 3'd7)
        flash <= ~flash;

      if (!i_Collided)
        coll_block <= 1'b0;
      else if (state == PLAY && collide_hit)
        coll_block <= 1'b1;

      case (state)
        IDLE, GAME_OVER: begin
          if (start_edge) begin
            lives    <= LIVES_INIT;
            score    <= '0;
            level    <= '0;
            step_cnt <= '0;
          end
        end
        PLAY: begin
          if (collide_hit) begin
            if (lives != 2'd0) lives <= lives - 2'd1;
          end else if (goal_hit && score < MAX_SCORE) begin
            score <= score + 7'd1;
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              if (level < MAX_LEVEL) level <= level + 3'd1;
            end else begin
              step_cnt <= step_cnt + STEP_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_State       = state;
  assign o_Frog_Reset  = frog_reset;
  assign o_Move_Enable = move_en;
  assign o_Cars_Enable = cars_en;
  assign o_Flash       = flash;
  assign o_Lives       = lives;
  assign o_Score       = score;
  assign o_Level       = level;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with default parameters.
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       start = 1'b0;
  logic       collided = 1'b0;
  logic [5:0] frog_y = 6'd10;
  logic [2:0] state;
  logic       frog_reset;
  logic       move_en;
  logic       cars_en;
  logic       flash;
  logic [1:0] lives;
  logic [6:0] score;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  game_state_ctrl dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_VSync      (vsync),
    .i_Game_Start (start),
    .i_Collided   (collided),
    .i_Frogger_Y  (frog_y),
    .o_State      (state),
    .o_Frog_Reset (frog_reset),
    .o_Move_Enable(move_en),
    .o_Cars_Enable(cars_en),
    .o_Flash      (flash),
    .o_Lives      (lives),
    .o_Score      (score),
    .o_Level      (level)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b1;
    step(1);
    vsync = 1'b0;
    step(1);
  endtask

  task automatic goal();
    frog_y = 6'd0;
    step(1);
    frog_y = 6'd5;
    repeat (30) frame();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_state", 32'(state), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_score", 32'(score), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_move", 32'(move_en), 0);
    chk("rst_cars", 32'(cars_en), 0);
    chk("rst_flash", 32'(flash), 0);
    chk("rst_frog", 32'(frog_reset), 0);

    // Start game
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("start_state", 32'(state), 1);
    chk("start_lives", 32'(lives), 3);
    chk("start_score", 32'(score), 0);
    chk("start_frog", 32'(frog_reset), 1);
    chk("start_move", 32'(move_en), 1);
    chk("start_cars", 32'(cars_en), 1);
    step(1);
    chk("start_frog_end", 32'(frog_reset), 0);

    // Start edge ignored in PLAY
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("play_start_ign", 32'(state), 1);
    step(1);

    // First goal
    frog_y = 6'd0;
    step(1);
    frog_y = 6'd5;
    chk("goal_state", 32'(state), 3);
    chk("goal_score", 32'(score), 1);
    chk("goal_frog", 32'(frog_reset), 1);
    chk("goal_move", 32'(move_en), 0);
    chk("goal_cars", 32'(cars_en), 1);
    repeat (29) frame();
    chk("scored_29", 32'(state), 3);
    frame();
    chk("scored_30", 32'(state), 1);

    // Goals 2..5: level increments on the fifth
    repeat (3) goal();
    chk("score4", 32'(score), 4);
    chk("level0", 32'(level), 0);
    goal();
    chk("score5", 32'(score), 5);
    chk("level1", 32'(level), 1);

    // Goals 6..99, then one more at saturation
    repeat (94) goal();
    chk("score99", 32'(score), 99);
    chk("level_sat", 32'(level), 7);
    frog_y = 6'd0;
    step(1);
    frog_y = 6'd5;
    chk("sat_state", 32'(state), 3);
    chk("sat_score", 32'(score), 99);
    chk("sat_level", 32'(level), 7);
    repeat (30) frame();
    chk("sat_back", 32'(state), 1);

    // Held collision at the goal row: dying wins over scoring
    frog_y = 6'd0;
    collided = 1'b1;
    step(1);
    chk("die_state", 32'(state), 2);
    chk("die_lives", 32'(lives), 2);
    chk("die_flash", 32'(flash), 1);
    chk("die_move", 32'(move_en), 0);
    chk("die_cars", 32'(cars_en), 1);
    chk("die_score", 32'(score), 99);
    step(99);
    chk("hold_state", 32'(state), 2);
    chk("hold_lives", 32'(lives), 2);
    collided = 1'b0;
    frog_y = 6'd5;
    repeat (7) frame();
    chk("flash_t7", 32'(flash), 1);
    frame();
    chk("flash_t8", 32'(flash), 0);
    repeat (8) frame();
    chk("flash_t16", 32'(flash), 1);
    repeat (43) frame();
    chk("die_59", 32'(state), 2);
    frame();
    chk("die_60", 32'(state), 1);
    chk("die_end_flash", 32'(flash), 0);
    chk("die_end_move", 32'(move_en), 1);

    // Second and third collisions lead to game over
    collided = 1'b1;
    step(1);
    collided = 1'b0;
    chk("die2_lives", 32'(lives), 1);
    repeat (60) frame();
    chk("die2_back", 32'(state), 1);
    collided = 1'b1;
    step(1);
    collided = 1'b0;
    chk("die3_lives", 32'(lives), 0);
    repeat (60) frame();
    chk("go_state", 32'(state), 4);
    chk("go_move", 32'(move_en), 0);
    chk("go_cars", 32'(cars_en), 0);
    chk("go_flash", 32'(flash), 0);
    chk("go_score", 32'(score), 99);
    chk("go_level", 32'(level), 7);

    // Restart from game over
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("restart_state", 32'(state), 1);
    chk("restart_lives", 32'(lives), 3);
    chk("restart_score", 32'(score), 0);
    chk("restart_level", 32'(level), 0);
    chk("restart_frog", 32'(frog_reset), 1);
    step(1);

    // Reset in the middle of DYING
    collided = 1'b1;
    step(1);
    collided = 1'b0;
    chk("mid_die_state", 32'(state), 2);
    repeat (10) frame();
    rst = 1'b1;
    step(1);
    chk("mr_state", 32'(state), 0);
    chk("mr_lives", 32'(lives), 3);
    chk("mr_score", 32'(score), 0);
    chk("mr_level", 32'(level), 0);
    chk("mr_frog", 32'(frog_reset), 0);
    chk("mr_move", 32'(move_en), 0);
    chk("mr_cars", 32'(cars_en), 0);
    chk("mr_flash", 32'(flash), 0);
    rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter c_LIVES, default 3, meaning lives loaded at game start (range 1..3).
REQ-002 SHALL have parameter c_DEATH_FRAMES, default 60, meaning frames spent in DYING.
REQ-003 SHALL have parameter c_SCORE_FRAMES, default 30, meaning frames spent in SCORED.
REQ-004 SHALL have parameter c_LEVEL_STEP, default 5, meaning goals per level increment.
REQ-005 SHALL have parameter c_MAX_LEVEL, default 7, meaning level saturation value.
REQ-006 SHALL have parameter c_MAX_SCORE, default 99, meaning score saturation value.
REQ-007 SHALL have parameter c_GOAL_ROW, default 0, meaning frog tile row that counts as a goal.
REQ-008 SHALL have port i_Clk, input, 1 bit, meaning the single system clock.
REQ-009 SHALL have port i_Reset, input, 1 bit, meaning synchronous active-high reset.
REQ-010 SHALL have port i_VSync, input, 1 bit, meaning the frame sync; a rising edge is one frame tick.
REQ-011 SHALL have port i_Game_Start, input, 1 bit, meaning the start button (level).
REQ-012 SHALL have port i_Collided, input, 1 bit, meaning frog/car collision.
REQ-013 SHALL have port i_Frogger_Y, input, 6 bits, meaning frog tile row.
REQ-014 SHALL have port o_State, output, 3 bits, meaning current state: IDLE=0, PLAY=1, DYING=2, SCORED=3, GAME_OVER=4.
REQ-015 SHALL have port o_Frog_Reset, output, 1 bit, meaning a 1-cycle pulse that returns the frog to spawn.
REQ-016 SHALL have port o_Move_Enable, output, 1 bit, meaning frog movement is allowed.
REQ-017 SHALL have port o_Cars_Enable, output, 1 bit, meaning car motion is allowed.
REQ-018 SHALL have port o_Flash, output, 1 bit, meaning the death blink for video.
REQ-019 SHALL have port o_Lives, output, 2 bits; o_Score, output, 7 bits; and o_Level, output, 3 bits.

Function
REQ-020 SHALL register i_VSync and i_Game_Start and derive 1-cycle rising-edge pulses (frame tick, start edge) from them.
REQ-021 SHALL drive all outputs from registers; outputs change one cycle after the causing input edge.
REQ-022 In IDLE, SHALL drive o_Move_Enable=0 and o_Cars_Enable=0; on a start edge SHALL go to PLAY with lives=c_LIVES, score=0, level=0.
REQ-023 In PLAY, SHALL drive o_Move_Enable=1 and o_Cars_Enable=1.
REQ-024 In PLAY with i_Collided=1, SHALL go to DYING and decrement lives once; collision has priority over goal.
REQ-025 In PLAY with i_Frogger_Y==c_GOAL_ROW and no collision, SHALL go to SCORED and increment score, saturating at c_MAX_SCORE.
REQ-026 SHALL keep a goal step counter 0..c_LEVEL_STEP-1; when it wraps, level increments, saturating at c_MAX_LEVEL.
REQ-027 SHALL not advance score, step counter or level on a goal while score is saturated.
REQ-028 In DYING, SHALL drive o_Move_Enable=0 and o_Cars_Enable=1, and toggle o_Flash every 8 frame ticks (starting at 1 on entry); o_Flash=0 in all other states.
REQ-029 After c_DEATH_FRAMES frame ticks in DYING, SHALL go to GAME_OVER if lives==0, else to PLAY.
REQ-030 In SCORED, SHALL drive o_Move_Enable=0 and o_Cars_Enable=1; after c_SCORE_FRAMES frame ticks SHALL go to PLAY.
REQ-031 In GAME_OVER, SHALL drive both enables to 0 and hold score/level; a start edge SHALL behave as in IDLE.
REQ-032 SHALL clear the frame counter on every state entry; a frame tick in the entry cycle is not counted.
REQ-033 SHALL assert o_Frog_Reset for exactly the first cycle of every entry into PLAY or SCORED.
REQ-034 SHALL ignore start edges in PLAY, DYING and SCORED.
REQ-035 SHALL decrement lives only once while i_Collided is held high; lives never underflow below 0.

Reset
REQ-036 On i_Reset=1 at a clock edge, from any state, SHALL set: o_State=IDLE, o_Lives=c_LIVES, o_Score=0, o_Level=0, o_Frog_Reset=0, o_Move_Enable=0, o_Cars_Enable=0, o_Flash=0, counters and edge registers=0.

Verification
REQ-037 Reset, then start pulse -> o_State=1, o_Lives=3, o_Score=0, and o_Frog_Reset high for 1 cycle.
REQ-038 In PLAY, set i_Frogger_Y=0 -> SCORED, o_Score=1, o_Frog_Reset pulse; after 30 VSync edges -> o_State=1.
REQ-039 Five goals -> o_Level=1; 99 goals with c_MAX_SCORE=99 and one more -> o_Score stays 99.
REQ-040 Hold i_Collided=1 for 100 cycles with i_Frogger_Y=0 -> DYING, o_Lives=2 (not SCORED), o_Flash toggles every 8 frames, PLAY after 60 frames.
REQ-041 Three collisions -> GAME_OVER, enables=0, score held; start edge -> PLAY, o_Lives=3, o_Score=0.
REQ-042 Assert i_Reset mid-DYING -> next cycle o_State=0 and all outputs at their reset values.
